mem_port_arbiter: RTL and testbench

Arbitrates the single memory port between instruction fetch and the execute stage's data access (`mem_req`/`mem_we`). It sequences one transaction at a time over a req/ack memory handshake and returns data and acks to the winner. It also produces the pipeline stall that drives the stages' `clk_en` low. Pending fetches are discarded on a taken jump.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one req/ack memory port between instruction fetch and
//                the execute stage's data access. One transaction at a time;
//                data has fixed priority over fetch. A taken jump (flush)
//                discards any pending or in-flight fetch. Produces the
//                pipeline stall that gates the stages' clock enable.
//
//  Ports       : clk, rst_n                  clock, synchronous active-low reset
//                if_req/if_addr              fetch request and word address
//                if_rdata/if_ack             fetch data and 1-cycle completion
//                dm_req/dm_we/dm_addr/dm_wdata  data request from execute
//                dm_rdata/dm_ack             load data and 1-cycle completion
//                flush                       taken jump, kills fetches
//                mem_req/mem_we/mem_addr/mem_wdata  memory port request side
//                mem_rdata/mem_ack           memory port response side
//                pipe_stall                  combinational, clk_en = ~pipe_stall
//                bus_err                     1-cycle timeout pulse
//
//  Build option: MEM_ARB_TIMEOUT_EN -- when defined, a transaction that sees
//                no mem_ack for TIMEOUT_CYC cycles (TIMEOUT_CYC >= 1) is
//                abandoned: the owner gets its ack with zero data and bus_err
//                pulses. When undefined, transactions wait indefinitely and
//                bus_err is constant 0.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 30,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              pipe_stall,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t state;
    logic   kill;       // current fetch was overtaken by a jump
    logic   timeout;    // abandon the active transaction at this edge
    logic   done;       // active transaction ends at this edge

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt;   // wait cycles already elapsed in this transaction
    logic             bus_err_q;

    assign timeout = (state != ST_IDLE) && !mem_ack && (wait_cnt == CNT_LAST);
    assign bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (state == ST_IDLE || mem_ack) begin
                // Every grant starts from IDLE, so the count is fresh per transaction.
                wait_cnt <= '0;
            end else if (timeout) begin
                wait_cnt  <= '0;
                bus_err_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign done = (state != ST_IDLE) && (mem_ack || timeout);

    // A requester's req is still high during its ack cycle; masking with the
    // ack lets the stall drop that cycle and keeps IDLE from re-granting it.
    assign pipe_stall = (dm_req & ~dm_ack) | (if_req & ~if_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dm_ack    <= 1'b0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
        end else begin
            dm_ack <= 1'b0;
            if_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (dm_req && !dm_ack) begin
                        state     <= ST_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req && !if_ack && !flush) begin
                        state     <= ST_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end

                ST_DATA: begin
                    if (done) begin
                        dm_ack   <= 1'b1;
                        dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : 32'd0;
                    end
                end

                ST_FETCH: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    // A jump in the completing cycle also discards the fetch.
                    if (done && !kill && !flush) begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_ack ? mem_rdata : 32'd0;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            if (done) begin
                state     <= ST_IDLE;
                kill      <= 1'b0;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//                followed by randomized requesters, flushes and memory
//                latency, all compared cycle by cycle against a
//                transaction-level reference model.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W      = 30;
    localparam int TIMEOUT_CYC = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;
    logic              flush;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              pipe_stall;
    logic              bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .pipe_stall (pipe_stall),
        .bus_err    (bus_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the transaction currently owning the bus, plus the
    // responses the requesters should see after each edge.
    // ------------------------------------------------------------------
    bit              m_busy = 0;
    bit              m_data = 0;
    bit              m_kill = 0;
    bit              m_we   = 0;
    bit [ADDR_W-1:0] m_addr = '0;
    bit [31:0]       m_wdata = '0;
    int              m_wait = 0;
    bit              e_dm_ack = 0;
    bit              e_if_ack = 0;
    bit              e_bus_err = 0;
    bit [31:0]       e_dm_rdata = '0;
    bit [31:0]       e_if_rdata = '0;

    task automatic model_finish(input logic [31:0] rd, input bit to);
        if (m_data) begin
            e_dm_ack   = 1;
            e_dm_rdata = m_we ? 32'd0 : rd;
        end else if (!m_kill) begin
            e_if_ack   = 1;
            e_if_rdata = rd;
        end
        e_bus_err = to;
        m_busy  = 0;
        m_kill  = 0;
        m_we    = 0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic model_step();
        bit dm_was;
        bit if_was;
        dm_was    = e_dm_ack;
        if_was    = e_if_ack;
        e_dm_ack  = 0;
        e_if_ack  = 0;
        e_bus_err = 0;
        if (!rst_n) begin
            m_busy = 0; m_kill = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            e_dm_rdata = '0; e_if_rdata = '0;
        end else if (!m_busy) begin
            if (dm_req && !dm_was) begin
                m_busy = 1; m_data = 1; m_addr = dm_addr; m_we = dm_we;
                m_wdata = dm_wdata; m_wait = 0;
            end else if (if_req && !if_was && !flush) begin
                m_busy = 1; m_data = 0; m_addr = if_addr; m_we = 0;
                m_wdata = '0; m_kill = 0; m_wait = 0;
            end
        end else begin
            if (!m_data && flush) m_kill = 1;
            if (mem_ack) begin
                model_finish(mem_rdata, 1'b0);
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TIMEOUT_CYC) model_finish(32'd0, 1'b1);
            end
`endif
        end
    endtask

    function automatic bit exp_stall();
        return (dm_req && !e_dm_ack) || (if_req && !e_if_ack);
    endfunction

    // ------------------------------------------------------------------
    // One clock: check the combinational stall on the settled inputs, let
    // the edge happen, advance the model, check all registered outputs.
    // ------------------------------------------------------------------
    int stall_cnt = 0;

    task automatic tick();
        #1;
        chk("pipe_stall", 32'(pipe_stall), 32'(exp_stall()));
        stall_cnt += int'(pipe_stall);
        @(posedge clk);
        model_step();
        #1;
        chk("mem_req",   32'(mem_req),   32'(m_busy));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("dm_ack",    32'(dm_ack),    32'(e_dm_ack));
        chk("if_ack",    32'(if_ack),    32'(e_if_ack));
        chk("bus_err",   32'(bus_err),   32'(e_bus_err));
        if (e_dm_ack) chk("dm_rdata", dm_rdata, e_dm_rdata);
        if (e_if_ack) chk("if_rdata", if_rdata, e_if_rdata);
    endtask

    // ------------------------------------------------------------------
    // Environment: memory responder and requesters react after each edge.
    // ------------------------------------------------------------------
    int          lat_fixed = 0;      // < 0 selects random latency 0..3
    bit          rd_rand   = 1;
    logic [31:0] rd_val    = '0;
    bit          rand_mode = 0;
    bit          in_txn    = 0;
    int          lat_left  = 0;
    bit          dm_drop   = 0;
    bit          if_drop   = 0;

    task automatic react();
        if (!mem_req) in_txn = 0;   // abandoned or finished request
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req && !in_txn) begin
            in_txn   = 1;
            lat_left = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
        end
        if (in_txn) begin
            if (lat_left == 0) begin
                mem_ack = 1'b1;
                if (!rd_rand) mem_rdata = rd_val;
                in_txn = 0;
            end else begin
                lat_left--;
            end
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;     // stray ack on an idle bus
        end

        flush = 1'b0;
        if (dm_req && dm_drop) begin
            dm_req = 1'b0;
        end else if (!dm_req && rand_mode && $urandom_range(0, 3) == 0) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom);
            dm_addr  = ADDR_W'($urandom);
            dm_wdata = $urandom;
        end
        dm_drop = dm_ack;

        if (if_req && if_drop) begin
            if_req = 1'b0;
        end else if (rand_mode && !if_ack && $urandom_range(0, 11) == 0) begin
            flush   = 1'b1;
            if_req  = 1'b1;
            if_addr = ADDR_W'($urandom);
        end else if (!if_req && rand_mode && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = ADDR_W'($urandom);
        end
        if_drop = if_ack;
    endtask

    task automatic run_until(input string tag, input bit want_if, input int bound, output int n);
        bit seen;
        seen = 0;
        n    = 0;
        while (!seen && n < bound) begin
            tick();
            n++;
            seen = want_if ? if_ack : dm_ack;
            react();
        end
        if (!seen) chk({tag, "_no_ack"}, 32'd0, 32'd1);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            react();
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        dm_req = 1'b0;
        if_req = 1'b0;
        flush  = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mr_cnt;
        int be_cnt;
        int da_cnt;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        do_reset();

        // Zero-wait fetch
        lat_fixed = 0; rd_rand = 0; rd_val = 32'hDEADBEEF;
        stall_cnt = 0;
        if_req = 1'b1; if_addr = 30'h10;
        run_until("zw_fetch", 1'b1, 10, n);
        chk("zw_fetch_latency", 32'(n), 32'd2);
        chk("zw_fetch_rdata", if_rdata, 32'hDEADBEEF);
        run(2);
        chk("zw_fetch_stall_cycles", 32'(stall_cnt), 32'd2);

        // Simultaneous data write and fetch: data first, then fetch
        rd_rand = 1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 30'h20; dm_wdata = 32'h12345678;
        if_req = 1'b1; if_addr = 30'h30;
        tick();
        chk("prio_mem_we", 32'(mem_we), 32'd1);
        chk("prio_mem_wdata", mem_wdata, 32'h12345678);
        react();
        run_until("prio_fetch", 1'b1, 20, n);
        chk("prio_fetch_after_data", 32'(n), 32'd3);
        run(3);

        // Fetch with 4-cycle latency, flushed on its 2nd wait cycle
        lat_fixed = 3;
        if_req = 1'b1; if_addr = 30'h50;
        tick(); react();
        tick(); react();
        flush = 1'b1; if_addr = 30'h40;
        tick(); react();
        run_until("refetch", 1'b1, 30, n);
        run(2);

        // Load with 2 wait states
        lat_fixed = 2; rd_rand = 0; rd_val = 32'hCAFE0001;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h08;
        run_until("load", 1'b0, 20, n);
        chk("load_latency", 32'(n), 32'd4);
        chk("load_rdata", dm_rdata, 32'hCAFE0001);
        run(2);

        // Reset during a wait state, then the held request is served
        lat_fixed = 5; rd_rand = 1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h0C;
        tick(); react();
        tick(); react();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_dm_ack", 32'(dm_ack), 32'd0);
        rst_n = 1'b1;
        lat_fixed = 1;
        react();
        run_until("after_rst", 1'b0, 20, n);
        run(2);

        // Memory that never answers
        lat_fixed = 1000000;
        mr_cnt = 0; be_cnt = 0; da_cnt = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h14;
        for (int i = 0; i < 110; i++) begin
            tick();
            mr_cnt += int'(mem_req);
            be_cnt += int'(bus_err);
            da_cnt += int'(dm_ack);
            react();
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to_mem_req_cycles", 32'(mr_cnt), 32'(TIMEOUT_CYC));
        chk("to_bus_err_pulses", 32'(be_cnt), 32'd1);
        chk("to_dm_ack_pulses", 32'(da_cnt), 32'd1);
`else
        chk("hang_mem_req_cycles", 32'(mr_cnt), 32'd110);
        chk("hang_bus_err_pulses", 32'(be_cnt), 32'd0);
        chk("hang_dm_ack_pulses", 32'(da_cnt), 32'd0);
`endif
        do_reset();

        // Randomized traffic
        lat_fixed = -1; rd_rand = 1; rand_mode = 1;
        dm_drop = 0; if_drop = 0; in_txn = 0;
        run(600);
        rand_mode = 0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
